// File: rtl/move_entry_ctrl.sv
// Player input front-end for the tictactoe board: debounced buttons, a
// wrapping 3x3 cursor, move validation and a single-shot move handshake.

// One button channel: two-flop synchroniser, debounce counter and a
// registered one-cycle pulse on each debounced press.
module move_entry_btn #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press
);

  localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic       sync1;
  logic       sync2;
  logic       level;
  logic [7:0] cnt;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after it has been seen on enough consecutive edges;
  // a 0->1 acceptance also fires the press pulse for exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == DEB_LAST) begin
        level <= sync2;
        cnt   <= '0;
        press <= sync2;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

// Top level: cursor, select validation and the request/confirm handshake.
module move_entry_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_sel,
  input  logic [17:0] board,
  input  logic [1:0]  winner,
  input  logic        tie,
  output logic [3:0]  x_in,
  output logic [3:0]  y_in,
  output logic        make_move,
  output logic [1:0]  cursor_r,
  output logic [1:0]  cursor_c,
  output logic        reject,
  output logic        busy
);

  localparam int BTN_RIGHT = 0;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_UP    = 3;
  localparam int BTN_SEL   = 4;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [4:0] raw_vec;
  logic [4:0] ev;
  logic [1:0] lat_r;
  logic [1:0] lat_c;
  logic [7:0] tcnt;
  logic [1:0] cur_cell;
  logic [1:0] tgt_cell;
  logic       game_over;
  logic       accept;
  logic       refuse;
  logic       expire;
  logic       dir_ok;

  // Returns the 2-bit code of cell (r,c); cell k=3r+c sits at bits [17-2k:16-2k].
  function automatic logic [1:0] cell_at(input logic [17:0] b,
                                         input logic [1:0]  r,
                                         input logic [1:0]  c);
    logic [3:0]  k;
    logic [17:0] sh;
    k  = 4'({r, 1'b0}) + 4'(r) + 4'(c);
    sh = b >> (5'd16 - {k, 1'b0});
    return sh[1:0];
  endfunction

  assign raw_vec = {btn_sel, btn_up, btn_down, btn_left, btn_right};

  genvar g;
  for (g = 0; g < 5; g++) begin : g_btn
    move_entry_btn #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (raw_vec[g]),
      .press(ev[g])
    );
  end

  assign cur_cell  = cell_at(board, cursor_r, cursor_c);
  assign tgt_cell  = cell_at(board, lat_r, lat_c);
  assign game_over = (winner != 2'b00) || tie;

  assign x_in      = {2'b00, lat_r};
  assign y_in      = {2'b00, lat_c};
  assign make_move = (state == ISSUE);
  assign busy      = (state != IDLE);

  // Directions only steer the cursor while idle, and a select in the same cycle wins.
  assign dir_ok = (state == IDLE) && !ev[BTN_SEL];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: validate selects while idle, issue once, then wait for the board.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    refuse     = 1'b0;
    expire     = 1'b0;
    case (state)
      IDLE: begin
        if (ev[BTN_SEL]) begin
          if (game_over || (cur_cell != 2'b00)) begin
            refuse = 1'b1;
          end else begin
            accept     = 1'b1;
            state_next = ISSUE;
          end
        end
      end
      ISSUE: begin
        state_next = WAIT;
      end
      WAIT: begin
        if (tgt_cell != 2'b00) begin
          state_next = IDLE;
        end else if (tcnt == TO_LAST) begin
          expire     = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Wrapping cursor, highest-priority direction event only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cursor_r <= 2'd0;
      cursor_c <= 2'd0;
    end else if (dir_ok) begin
      if (ev[BTN_UP]) begin
        cursor_r <= (cursor_r == 2'd0) ? 2'd2 : cursor_r - 2'd1;
      end else if (ev[BTN_DOWN]) begin
        cursor_r <= (cursor_r == 2'd2) ? 2'd0 : cursor_r + 2'd1;
      end else if (ev[BTN_LEFT]) begin
        cursor_c <= (cursor_c == 2'd0) ? 2'd2 : cursor_c - 2'd1;
      end else if (ev[BTN_RIGHT]) begin
        cursor_c <= (cursor_c == 2'd2) ? 2'd0 : cursor_c + 2'd1;
      end
    end
  end

  // Latch the requested cell, run the confirmation timer and pulse reject.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_r  <= 2'd0;
      lat_c  <= 2'd0;
      tcnt   <= '0;
      reject <= 1'b0;
    end else begin
      reject <= refuse || expire;
      if (accept) begin
        lat_r <= cursor_r;
        lat_c <= cursor_c;
      end
      if (state == ISSUE) begin
        tcnt <= '0;
      end else if (state == WAIT) begin
        tcnt <= tcnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_move_entry_ctrl.sv
// Scoreboard bench for move_entry_ctrl: randomised button sequences, a
// cell-level game model predicting move requests and rejects.
module tb_move_entry_ctrl;

  localparam int DEB = 4;
  localparam int TO  = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        btn_up, btn_down, btn_left, btn_right, btn_sel;
  logic [17:0] board;
  logic [17:0] setup_board;
  logic [17:0] played_board;
  logic [1:0]  winner;
  logic        tie;
  logic [3:0]  x_in, y_in;
  logic        make_move;
  logic [1:0]  cursor_r, cursor_c;
  logic        reject;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit respond_en = 1'b0;

  typedef struct {
    bit is_move;
    int at;
    int x;
    int y;
  } exp_t;
  exp_t exp_q[$];

  int mdl_r;
  int mdl_c;
  int mdl_cell[9];
  int mdl_busy_until;

  assign board = setup_board | played_board;

  move_entry_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .btn_left (btn_left),
    .btn_right(btn_right),
    .btn_sel  (btn_sel),
    .board    (board),
    .winner   (winner),
    .tie      (tie),
    .x_in     (x_in),
    .y_in     (y_in),
    .make_move(make_move),
    .cursor_r (cursor_r),
    .cursor_c (cursor_c),
    .reject   (reject),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Button bit order: 4 sel, 3 up, 2 down, 1 left, 0 right.
  task automatic setButtons(input logic [4:0] m);
    btn_sel   = m[4];
    btn_up    = m[3];
    btn_down  = m[2];
    btn_left  = m[1];
    btn_right = m[0];
  endtask

  task automatic waitUntil(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic modelReset();
    mdl_r = 0;
    mdl_c = 0;
    mdl_busy_until = -1;
    for (int i = 0; i < 9; i++) mdl_cell[i] = 0;
  endtask

  // Game-level effect of the buttons in mask m acting at edge a.
  task automatic modelAct(input logic [4:0] m, input int a, input bit respond);
    exp_t e;
    int   k;
    if (m == 5'b0 || a <= mdl_busy_until) return;
    if (m[4]) begin
      k = mdl_r * 3 + mdl_c;
      if (winner != 2'b00 || tie || mdl_cell[k] != 0) begin
        e = '{is_move: 1'b0, at: a, x: 0, y: 0};
        exp_q.push_back(e);
      end else begin
        e = '{is_move: 1'b1, at: a, x: mdl_r, y: mdl_c};
        exp_q.push_back(e);
        if (respond) begin
          mdl_cell[k] = 1;
          mdl_busy_until = a + 2;
        end else begin
          e = '{is_move: 1'b0, at: a + 1 + TO, x: 0, y: 0};
          exp_q.push_back(e);
          mdl_busy_until = a + 1 + TO;
        end
      end
    end else if (m[3]) mdl_r = (mdl_r + 2) % 3;
    else if (m[2]) mdl_r = (mdl_r + 1) % 3;
    else if (m[1]) mdl_c = (mdl_c + 2) % 3;
    else mdl_c = (mdl_c + 1) % 3;
  endtask

  // Press 'first' for 'hold' cycles; 'late' joins 'late_delay' cycles later.
  task automatic applyStimulus(input logic [4:0] first, input int hold,
                               input logic [4:0] late, input int late_delay,
                               input bit respond);
    int k;
    int e0;
    respond_en = respond;
    @(negedge clk);
    k  = cyc;
    e0 = k + 1;
    if (late_delay == 0) begin
      if (hold >= DEB) modelAct(first | late, e0 + 2 + DEB, respond);
    end else begin
      if (hold >= DEB) modelAct(first, e0 + 2 + DEB, respond);
      if (late != 5'b0 && hold - late_delay >= DEB)
        modelAct(late, e0 + late_delay + 2 + DEB, respond);
    end
    setButtons(first);
    for (int i = 0; i < hold; i++) begin
      if (i == late_delay) setButtons(first | late);
      @(negedge clk);
    end
    setButtons(5'b0);
    waitUntil(k + hold + DEB + TO + 12);
    checkOutput("cursor_r", int'(cursor_r), mdl_r);
    checkOutput("cursor_c", int'(cursor_c), mdl_c);
    checkOutput("busy_idle", int'(busy), 0);
    checkOutput("pending_outputs", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_x_in", int'(x_in), 0);
    checkOutput("rst_y_in", int'(y_in), 0);
    checkOutput("rst_make_move", int'(make_move), 0);
    checkOutput("rst_reject", int'(reject), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_cursor_r", int'(cursor_r), 0);
    checkOutput("rst_cursor_c", int'(cursor_c), 0);
  endtask

  task automatic resetMidWait();
    int k;
    respond_en = 1'b0;
    winner = 2'b00;
    tie = 1'b0;
    @(negedge clk);
    k = cyc;
    modelAct(5'b10000, k + 3 + DEB, 1'b0);
    setButtons(5'b10000);
    repeat (DEB + 2) @(negedge clk);
    setButtons(5'b0);
    waitUntil(k + 3 + DEB + 3);
    checkOutput("busy_in_wait", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    checkResetOutputs();
    repeat (3) @(negedge clk);
    checkOutput("pending_at_reset", exp_q.size(), 1);
    exp_q.delete();
    modelReset();
    setup_board = '0;
    rst_n = 1'b1;
    repeat (TO + 10) @(negedge clk);
    checkOutput("cursor_r_after_reset", int'(cursor_r), 0);
    checkOutput("cursor_c_after_reset", int'(cursor_c), 0);
  endtask

  // Emulates tictactoe: the requested cell becomes X when responses are enabled.
  initial begin : responder
    int k;
    played_board = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        played_board = '0;
      end else if (make_move && respond_en && x_in < 4'd3 && y_in < 4'd3) begin
        k = 3 * int'(x_in) + int'(y_in);
        played_board[17 - 2 * k -: 2] = 2'b01;
      end
    end
  end

  // Monitor: every make_move or reject must match the next expected response.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (make_move || reject)) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_output: got make_move=%0b reject=%0b, expected none (cycle %0d)",
                   make_move, reject, cyc);
        end else begin
          e = exp_q.pop_front();
          checkOutput("output_is_move", int'(make_move), int'(e.is_move));
          checkOutput("output_cycle", cyc, e.at);
          if (e.is_move) begin
            checkOutput("x_in", int'(x_in), e.x);
            checkOutput("y_in", int'(y_in), e.y);
            checkOutput("busy_at_move", int'(busy), 1);
          end else begin
            checkOutput("busy_at_reject", int'(busy), 0);
          end
        end
      end
    end
  end

  initial begin : stimulus
    logic [4:0] first;
    logic [4:0] late;
    int op;
    int j;
    rst_n = 1'b0;
    setButtons(5'b0);
    setup_board = '0;
    winner = 2'b00;
    tie = 1'b0;
    modelReset();
    #1;
    checkResetOutputs();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(5'b00001, 10, 5'b0, 0, 1'b1);
    applyStimulus(5'b00001, 10, 5'b0, 0, 1'b1);
    applyStimulus(5'b00100, 10, 5'b0, 0, 1'b1);
    applyStimulus(5'b10000, 10, 5'b0, 0, 1'b1);
    applyStimulus(5'b10000, 10, 5'b0, 0, 1'b1);
    applyStimulus(5'b01000, 10, 5'b0, 0, 1'b0);
    applyStimulus(5'b00010, 10, 5'b0, 0, 1'b0);
    applyStimulus(5'b00010, 10, 5'b0, 0, 1'b0);
    applyStimulus(5'b01000, 10, 5'b0, 0, 1'b0);
    applyStimulus(5'b00010, 10, 5'b0, 0, 1'b0);
    applyStimulus(5'b00100, 10, 5'b0, 0, 1'b0);
    applyStimulus(5'b00001, 10, 5'b0, 0, 1'b0);
    applyStimulus(5'b10000, DEB - 1, 5'b0, 0, 1'b1);
    applyStimulus(5'b10000, 50, 5'b0, 0, 1'b1);
    applyStimulus(5'b00001, 10, 5'b0, 0, 1'b1);
    applyStimulus(5'b11000, 10, 5'b0, 0, 1'b1);
    applyStimulus(5'b00100, 10, 5'b0, 0, 1'b1);
    winner = 2'b01;
    applyStimulus(5'b10000, 10, 5'b0, 0, 1'b1);
    winner = 2'b00;
    tie = 1'b1;
    applyStimulus(5'b10000, 10, 5'b0, 0, 1'b1);
    tie = 1'b0;
    applyStimulus(5'b10000, 12, 5'b01000, 2, 1'b0);
    resetMidWait();

    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 9);
      if (op <= 4) begin
        first = 5'(1 << $urandom_range(0, 3));
        applyStimulus(first, $urandom_range(DEB, 20), 5'b0, 0, 1'b0);
      end else if (op == 5) begin
        first = 5'(1 << $urandom_range(0, 4));
        applyStimulus(first, $urandom_range(1, DEB - 1), 5'b0, 0, 1'b0);
      end else begin
        winner = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00;
        tie = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 2) == 0) begin
          j = $urandom_range(0, 8);
          if (mdl_cell[j] == 0) begin
            setup_board[17 - 2 * j -: 2] = 2'b10;
            mdl_cell[j] = 2;
          end
        end
        j = $urandom_range(0, 3);
        if (op <= 7) begin
          first = 5'b10000;
          late = 5'(1 << $urandom_range(0, 3));
        end else begin
          first = 5'(1 << $urandom_range(0, 3));
          late = 5'b10000;
        end
        applyStimulus(first, DEB + j + $urandom_range(0, 20), late, j, 1'($urandom_range(0, 1)));
        winner = 2'b00;
        tie = 1'b0;
      end
    end

    checkOutput("final_pending", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
